// File: rtl/lab2_proc_squash_drop_ctrl.sv
// Squash-driven response dropper between a requester and its memory port.
// Tracks outstanding requests and discards responses owed to squashed requests.
module lab2_proc_squash_drop_ctrl #(
    parameter int p_req_nbits    = 77,
    parameter int p_resp_nbits   = 47,
    parameter int p_max_inflight = 4,
    localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    squash,

    input  logic [p_req_nbits-1:0]  procreq_msg,
    input  logic                    procreq_val,
    output logic                    procreq_rdy,

    output logic [p_req_nbits-1:0]  memreq_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,

    input  logic [p_resp_nbits-1:0] memresp_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,

    output logic [p_resp_nbits-1:0] procresp_msg,
    output logic                    procresp_val,
    input  logic                    procresp_rdy,

    output logic [c_cnt_nbits-1:0]  inflight,
    output logic [c_cnt_nbits-1:0]  drop_cnt,
    output logic                    draining
);

    logic [c_cnt_nbits-1:0] inflight_reg, inflight_next;
    logic [c_cnt_nbits-1:0] drop_cnt_reg, drop_cnt_next;
    logic                   full;
    logic                   drop_mode;
    logic                   req_go;
    logic                   resp_go;
    logic                   resp_cnt;

    assign full      = (inflight_reg == c_cnt_nbits'(p_max_inflight));
    assign drop_mode = (drop_cnt_reg != '0) || squash;

    assign memreq_msg   = procreq_msg;
    assign procresp_msg = memresp_msg;

    // Handshake outputs are held low while reset is asserted.
    assign memreq_val   = reset && procreq_val && !squash && !full;
    assign procreq_rdy  = reset && memreq_rdy && !squash && !full;
    assign procresp_val = reset && !drop_mode && memresp_val;
    assign memresp_rdy  = reset && (drop_mode || procresp_rdy);

    assign req_go   = memreq_val && memreq_rdy;
    assign resp_go  = memresp_val && memresp_rdy;
    // A stray response with nothing outstanding must not wrap the counter.
    assign resp_cnt = resp_go && (inflight_reg != '0);

    always_comb begin
        inflight_next = inflight_reg + c_cnt_nbits'(req_go) - c_cnt_nbits'(resp_cnt);
        drop_cnt_next = drop_cnt_reg;
        if (squash) begin
            drop_cnt_next = inflight_reg - c_cnt_nbits'(resp_cnt);
        end else if (resp_go && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - c_cnt_nbits'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign inflight = inflight_reg;
    assign drop_cnt = drop_cnt_reg;
    assign draining = (drop_cnt_reg != '0);

    resp_without_req: assert property (@(posedge clk) disable iff (!reset)
        !(memresp_val && (inflight_reg == '0)));

endmodule

// File: tb/tb_lab2_proc_squash_drop_ctrl.sv
// Bench for lab2_proc_squash_drop_ctrl: directed vector table, async reset
// sequence and randomized traffic against a queue-based reference model.
module tb_lab2_proc_squash_drop_ctrl;

    localparam int RQ = 77;
    localparam int RS = 47;
    localparam int MX = 4;
    localparam int CW = $clog2(MX + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          squash;
    logic [RQ-1:0] procreq_msg;
    logic          procreq_val, procreq_rdy;
    logic [RQ-1:0] memreq_msg;
    logic          memreq_val, memreq_rdy;
    logic [RS-1:0] memresp_msg;
    logic          memresp_val, memresp_rdy;
    logic [RS-1:0] procresp_msg;
    logic          procresp_val, procresp_rdy;
    logic [CW-1:0] inflight, drop_cnt;
    logic          draining;

    always #5 clk = ~clk;

    lab2_proc_squash_drop_ctrl #(
        .p_req_nbits(RQ), .p_resp_nbits(RS), .p_max_inflight(MX)
    ) dut (
        .clk(clk), .reset(reset), .squash(squash),
        .procreq_msg(procreq_msg), .procreq_val(procreq_val), .procreq_rdy(procreq_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .procresp_msg(procresp_msg), .procresp_val(procresp_val), .procresp_rdy(procresp_rdy),
        .inflight(inflight), .drop_cnt(drop_cnt), .draining(draining)
    );

    // Each outstanding request, in order, with whether its response is owed as a drop.
    typedef struct {
        logic          marked;
        logic [RS-1:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic sq, pv, mr, rv, pr;
        logic mv, prdy, pvo, mrr;
        int   inf, drp;
    } vec_t;
    vec_t tbl[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic e_req_go, e_resp_go;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_marked();
        int n = 0;
        foreach (q[i]) if (q[i].marked) n++;
        return n;
    endfunction

    task automatic drive(input logic sq, input logic pv, input logic mr, input logic rv, input logic pr);
        squash       = sq;
        procreq_val  = pv;
        memreq_rdy   = mr;
        memresp_val  = rv;
        procresp_rdy = pr;
        procreq_msg  = {13'($urandom), $urandom, $urandom};
        memresp_msg  = (q.size() > 0) ? q[0].data : {15'($urandom), $urandom};
    endtask

    task automatic check_model();
        logic full, dm, e_mv, e_prdy, e_pv, e_mrr;
        full   = (q.size() == MX);
        dm     = squash || (q.size() > 0 && q[0].marked);
        e_mv   = procreq_val && !squash && !full;
        e_prdy = memreq_rdy && !squash && !full;
        e_pv   = !dm && memresp_val;
        e_mrr  = dm || procresp_rdy;
        chk("memreq_val",   memreq_val,   e_mv);
        chk("procreq_rdy",  procreq_rdy,  e_prdy);
        chk("procresp_val", procresp_val, e_pv);
        chk("memresp_rdy",  memresp_rdy,  e_mrr);
        chk("inflight",     inflight,     q.size());
        chk("drop_cnt",     drop_cnt,     n_marked());
        chk("draining",     draining,     n_marked() != 0);
        chk("memreq_msg",   memreq_msg,   procreq_msg);
        chk("procresp_msg", procresp_msg, memresp_msg);
        if (e_pv) chk("resp_order", procresp_msg, q[0].data);
        e_req_go  = e_mv && memreq_rdy;
        e_resp_go = memresp_val && e_mrr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (e_resp_go && q.size() > 0) void'(q.pop_front());
        if (squash) foreach (q[i]) q[i].marked = 1'b1;
        if (e_req_go) q.push_back('{1'b0, ~procreq_msg[RS-1:0]});
    endtask

    task automatic run(input logic sq, input logic pv, input logic mr, input logic rv, input logic pr);
        drive(sq, pv, mr, rv, pr);
        #4;
        check_model();
        advance();
    endtask

    initial begin
        // sq pv mr rv pr | mv prdy pvo mrr | inflight drop_cnt (before the edge)
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 0,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 1,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 2,0});
        tbl.push_back('{0,0,1,1,1, 0,1,1,1, 3,0});
        tbl.push_back('{0,0,1,1,1, 0,1,1,1, 2,0});
        tbl.push_back('{0,0,1,1,1, 0,1,1,1, 1,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 0,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 1,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 2,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 3,0});
        tbl.push_back('{0,1,1,0,1, 0,0,0,1, 4,0});
        tbl.push_back('{0,1,1,1,1, 0,0,1,1, 4,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 3,0});
        tbl.push_back('{0,0,1,1,1, 0,0,1,1, 4,0});
        tbl.push_back('{1,1,1,0,1, 0,0,0,1, 3,0});
        tbl.push_back('{0,1,1,0,0, 1,1,0,1, 3,3});
        tbl.push_back('{0,0,1,1,0, 0,0,0,1, 4,3});
        tbl.push_back('{0,0,1,1,0, 0,1,0,1, 3,2});
        tbl.push_back('{0,0,1,1,0, 0,1,0,1, 2,1});
        tbl.push_back('{0,0,1,1,1, 0,1,1,1, 1,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 0,0});
        tbl.push_back('{0,1,1,0,1, 1,1,0,1, 1,0});
        tbl.push_back('{1,1,1,1,0, 0,0,0,1, 2,0});
        tbl.push_back('{0,0,1,0,0, 0,1,0,1, 1,1});
        tbl.push_back('{0,1,1,0,0, 1,1,0,1, 1,1});
        tbl.push_back('{1,0,1,0,0, 0,0,0,1, 2,1});
        tbl.push_back('{0,1,1,0,0, 1,1,0,1, 2,2});
        tbl.push_back('{1,0,1,0,0, 0,0,0,1, 3,2});
        tbl.push_back('{0,0,1,1,1, 0,1,0,1, 3,3});
        tbl.push_back('{0,0,1,1,1, 0,1,0,1, 2,2});
        tbl.push_back('{0,0,1,1,1, 0,1,0,1, 1,1});
        tbl.push_back('{0,0,1,0,0, 0,1,0,0, 0,0});

        reset = 1'b0;
        drive(0, 1, 1, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inflight",     inflight,     0);
        chk("rst_drop_cnt",     drop_cnt,     0);
        chk("rst_memreq_val",   memreq_val,   0);
        chk("rst_procreq_rdy",  procreq_rdy,  0);
        chk("rst_procresp_val", procresp_val, 0);
        chk("rst_memresp_rdy",  memresp_rdy,  0);
        drive(0, 0, 1, 0, 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].sq, tbl[i].pv, tbl[i].mr, tbl[i].rv, tbl[i].pr);
            #4;
            chk($sformatf("v%0d_memreq_val", i),   memreq_val,   tbl[i].mv);
            chk($sformatf("v%0d_procreq_rdy", i),  procreq_rdy,  tbl[i].prdy);
            chk($sformatf("v%0d_procresp_val", i), procresp_val, tbl[i].pvo);
            chk($sformatf("v%0d_memresp_rdy", i),  memresp_rdy,  tbl[i].mrr);
            chk($sformatf("v%0d_inflight", i),     inflight,     tbl[i].inf);
            chk($sformatf("v%0d_drop_cnt", i),     drop_cnt,     tbl[i].drp);
            check_model();
            advance();
        end

        // Build inflight=3, drop_cnt=2, then assert reset between edges.
        run(0, 1, 1, 0, 1);
        run(0, 1, 1, 0, 1);
        run(0, 1, 1, 0, 1);
        run(1, 0, 1, 1, 1);
        run(0, 1, 1, 0, 1);
        chk("pre_rst_inflight", inflight, 3);
        chk("pre_rst_drop_cnt", drop_cnt, 2);
        drive(0, 1, 1, 1, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_inflight",     inflight,     0);
        chk("arst_drop_cnt",     drop_cnt,     0);
        chk("arst_draining",     draining,     0);
        chk("arst_memreq_val",   memreq_val,   0);
        chk("arst_procreq_rdy",  procreq_rdy,  0);
        chk("arst_procresp_val", procresp_val, 0);
        chk("arst_memresp_rdy",  memresp_rdy,  0);
        @(posedge clk);
        #3;
        q.delete();
        drive(0, 0, 1, 0, 1);
        reset = 1'b1;
        run(0, 1, 1, 0, 1);
        drive(0, 0, 1, 1, 1);
        #4;
        chk("post_rst_pass", procresp_val, 1);
        check_model();
        advance();

        for (int i = 0; i < 3000; i++) begin
            run($urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0,
                (q.size() > 0) && ($urandom_range(0, 1) == 1),
                $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
